led_sequencer: RTL and testbench

Parametrised successor to the static LED pattern driver. It drives a Width-bit LED bank from a loadable pattern register in one of four animation modes: static, rotate, bounce and blink. Animation steps are paced by an internal programmable prescaler. The block sits between board-level control logic and the LED pins, and exports a step strobe for other display logic.

---
 rtl/led_sequencer.sv | 133 +++++++++++++
 tb/tb_led_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED bank animator: static, rotate-left, bounce and blink modes paced by a
// programmable prescaler, with a registered one-cycle step strobe.
module led_sequencer #(
  parameter int               Width        = 8,
  parameter int               PrescaleBits = 24,
  parameter logic [Width-1:0] Pattern      = Width'(8'b10010100)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    load,
  input  logic [Width-1:0]        pattern_i,
  input  logic [PrescaleBits-1:0] divider,
  output logic [Width-1:0]        leds,
  output logic                    tick
);

  localparam int              PosW    = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [PosW-1:0] LastPos = PosW'(Width - 1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  logic [Width-1:0]        pattern_q;
  mode_e                   mode_q;
  mode_e                   mode_in;
  logic                    mode_changed;
  logic [PrescaleBits-1:0] count_q;
  logic [PosW-1:0]         pos_q;
  logic [PosW-1:0]         pos_next;
  logic                    dir_down_q;
  logic                    dir_down_next;
  logic                    phase_on_q;

  function automatic logic [Width-1:0] rotl(input logic [Width-1:0] v);
    logic [Width-1:0] r;
    for (int i = 0; i < Width; i++) begin
      r[(i + 1) % Width] = v[i];
    end
    return r;
  endfunction

  function automatic logic [Width-1:0] onehot(input logic [PosW-1:0] p);
    logic [Width-1:0] r;
    r    = '0;
    r[p] = 1'b1;
    return r;
  endfunction

  // Bounce starts from a lit bit 0; every other mode starts from the pattern.
  function automatic logic [Width-1:0] reinit_leds(input mode_e m,
                                                   input logic [Width-1:0] pat);
    return (m == MODE_BOUNCE) ? onehot('0) : pat;
  endfunction

  assign mode_in      = mode_e'(mode);
  assign mode_changed = (mode_in != mode_q);

  always_comb begin
    pos_next      = pos_q;
    dir_down_next = dir_down_q;
    if (Width > 1) begin
      if (!dir_down_q) begin
        pos_next = pos_q + PosW'(1);
        if (pos_next == LastPos) dir_down_next = 1'b1;
      end else begin
        pos_next = pos_q - PosW'(1);
        if (pos_next == '0) dir_down_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern_q  <= Pattern;
      leds       <= Pattern;
      mode_q     <= MODE_STATIC;
      count_q    <= '0;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
      phase_on_q <= 1'b1;
      tick       <= 1'b0;
    end else if (load) begin
      pattern_q  <= pattern_i;
      mode_q     <= mode_in;
      leds       <= reinit_leds(mode_in, pattern_i);
      count_q    <= '0;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
      phase_on_q <= 1'b1;
      tick       <= 1'b0;
    end else if (mode_changed) begin
      mode_q     <= mode_in;
      leds       <= reinit_leds(mode_in, pattern_q);
      count_q    <= '0;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
      phase_on_q <= 1'b1;
      tick       <= 1'b0;
    end else if (enable) begin
      // >= so that shrinking the divider below the count fires immediately
      if (count_q >= divider) begin
        count_q <= '0;
        tick    <= 1'b1;
        case (mode_q)
          MODE_STATIC: leds <= pattern_q;
          MODE_ROTATE: leds <= rotl(leds);
          MODE_BOUNCE: begin
            pos_q      <= pos_next;
            dir_down_q <= dir_down_next;
            leds       <= onehot(pos_next);
          end
          MODE_BLINK: begin
            phase_on_q <= !phase_on_q;
            leds       <= phase_on_q ? '0 : pattern_q;
          end
          default: leds <= pattern_q;
        endcase
      end else begin
        count_q <= count_q + PrescaleBits'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a step-index reference model predicts
// leds/tick per edge, and a negedge monitor compares against the DUT.
module tb_led_sequencer;

  localparam logic [7:0] PAT = 8'b10010100;

  logic        clock     = 1'b0;
  logic        reset     = 1'b0;
  logic        enable    = 1'b1;
  logic [1:0]  mode      = 2'b00;
  logic        load      = 1'b0;
  logic [7:0]  pattern_i = 8'h00;
  logic [23:0] divider   = 24'd2;
  logic [7:0]  leds;
  logic        tick;

  led_sequencer #(.Width(8), .PrescaleBits(24), .Pattern(PAT)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .load     (load),
    .pattern_i(pattern_i),
    .divider  (divider),
    .leds     (leds),
    .tick     (tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] leds;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   fails  = 0;

  // Model: pattern, mode, prescale count and number of steps since reinit.
  logic [7:0]  m_pat   = PAT;
  logic [1:0]  m_mode  = 2'b00;
  logic [23:0] m_count = 24'd0;
  int          m_k     = 0;
  logic        m_tick  = 1'b0;

  function automatic logic [7:0] model_leds(input logic [1:0] md,
                                            input logic [7:0] pat, input int k);
    int s;
    int p;
    int pos;
    case (md)
      2'b00: return pat;
      2'b01: begin
        s = k % 8;
        return 8'((pat << s) | (pat >> (8 - s)));
      end
      2'b10: begin
        p   = k % 14;
        pos = (p <= 7) ? p : 14 - p;
        return 8'(8'd1 << pos);
      end
      default: return (k % 2 == 0) ? pat : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_pat = PAT; m_mode = 2'b00; m_count = 24'd0; m_k = 0; m_tick = 1'b0;
  endtask

  task automatic model_edge(input logic rst, input logic en, input logic [1:0] md,
                            input logic ld, input logic [7:0] pi,
                            input logic [23:0] dv);
    if (!rst) begin
      model_reset();
    end else if (ld) begin
      m_pat = pi; m_mode = md; m_count = 24'd0; m_k = 0; m_tick = 1'b0;
    end else if (md != m_mode) begin
      m_mode = md; m_count = 24'd0; m_k = 0; m_tick = 1'b0;
    end else if (en) begin
      if (m_count >= dv) begin
        m_count = 24'd0; m_k++; m_tick = 1'b1;
      end else begin
        m_count++; m_tick = 1'b0;
      end
    end else begin
      m_tick = 1'b0;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [1:0] md, input logic ld,
                     input logic [7:0] pi, input logic [23:0] dv);
    exp_t x;
    enable = en; mode = md; load = ld; pattern_i = pi; divider = dv;
    @(posedge clock);
    model_edge(reset, en, md, ld, pi, dv);
    x.leds = model_leds(m_mode, m_pat, m_k);
    x.tick = m_tick;
    exp_q.push_back(x);
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("leds", 32'(leds), 32'(e.leds));
      check("tick", 32'(tick), 32'(e.tick));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cur_mode;
    @(negedge clock);
    // Reset held across edges, then static mode ticking every third cycle
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 1'b0, 8'h00, 24'd2);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) cyc(1'b1, 2'b00, 1'b0, 8'h00, 24'd2);
    // Rotate every cycle
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b01, 1'b0, 8'h00, 24'd0);
    // Bounce, step every two cycles, covering both reversals
    for (int i = 0; i < 32; i++) cyc(1'b1, 2'b10, 1'b0, 8'h00, 24'd1);
    // Blink with a load arriving together with the mode change
    cyc(1'b1, 2'b11, 1'b1, 8'hF0, 24'd0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 2'b11, 1'b0, 8'h00, 24'd0);
    // Freeze mid-count, then resume
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b01, 1'b0, 8'h00, 24'd3);
    for (int i = 0; i < 10; i++) cyc(1'b0, 2'b01, 1'b0, 8'h00, 24'd3);
    for (int i = 0; i < 6; i++) cyc(1'b1, 2'b01, 1'b0, 8'h00, 24'd3);
    // Divider shrink below the running count
    cyc(1'b1, 2'b01, 1'b1, 8'h0F, 24'd20);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b01, 1'b0, 8'h00, 24'd20);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b01, 1'b0, 8'h00, 24'd4);
    // Asynchronous reset pulse between edges
    #2 reset = 1'b0;
    #1;
    check("async_reset_leds", 32'(leds), 32'(PAT));
    check("async_reset_tick", 32'(tick), 32'd0);
    model_reset();
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b01, 1'b0, 8'h00, 24'd0);
    // Randomised traffic
    cur_mode = 2'b01;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 9) != 0, cur_mode, $urandom_range(0, 29) == 0,
          8'($urandom), 24'($urandom_range(0, 4)));
    end
    @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
